fault_campaign_ctrl: RTL
========================

Name: fault_campaign_ctrl

Overview:
Sequences the fault-injectable cipher core through a full single-bit fault campaign. For each fault location 0..NUM_LOCS-1 it runs a golden encryption and a faulted encryption, captures both ciphertexts and computes the difference mask and Hamming weight. It streams one result record per location over a valid/ready interface. It sits between the board-level control (switches/UART) and the cipher core, replacing manual switch stepping.

Parameters:
DATA_W, 128, ciphertext width
LOC_W, 7, fault-location index width
NUM_LOCS, 128, locations per campaign (must be ≤ 2**LOC_W)
TIMEOUT, 64, max cycles to wait for core_done before flagging timeout
HW_W, 8, Hamming-weight width (must hold DATA_W)

Ports:
CLK_50  in  1  system clock, 50 MHz
RST_N  in  1  asynchronous active-low reset
start  in  1  campaign start pulse; ignored unless idle or done
busy  out  1  high from accepted start until DONE
done  out  1  level; high in DONE until next accepted start
core_start  out  1  one-cycle pulse launching one encryption
core_fault  out  1  fault enable to core
core_fault_loc  out  LOC_W  fault bit location to core
core_out  in  DATA_W  core ciphertext
core_done  in  1  core output valid (single-cycle)
res_valid  out  1  result record valid
res_ready  in  1  consumer ready
res_loc  out  LOC_W  location of this record
res_golden  out  DATA_W  golden ciphertext
res_diff  out  DATA_W  golden XOR faulted
res_hw  out  HW_W  popcount(res_diff)
res_timeout  out  1  either run of this record timed out

Behaviour:
- Reset: all outputs 0, state IDLE, loc counter 0, capture registers 0. Reset mid-campaign aborts immediately; no partial record emitted.
- States: IDLE, G_RUN, G_WAIT, F_RUN, F_WAIT, EMIT, DONE.
- IDLE/DONE --start--> G_RUN; loc=0, timeout flag cleared, done=0, busy=1.
- G_RUN: core_start=1 for one cycle, core_fault=0, core_fault_loc=loc -> G_WAIT.
- G_WAIT: on core_done capture core_out into golden reg -> F_RUN. Timeout counter counts cycles in WAIT; reaching TIMEOUT sets timeout flag, captures current core_out, proceeds.
- F_RUN: core_start=1 one cycle, core_fault=1 -> F_WAIT. core_fault/core_fault_loc held stable from F_RUN through F_WAIT; core_fault=0 elsewhere.
- F_WAIT: as G_WAIT, capture into faulty reg -> EMIT.
- EMIT: res_valid=1; res_diff/res_hw registered on EMIT entry (1-cycle compute, results stable throughout EMIT). On res_valid&&res_ready: if loc==NUM_LOCS-1 -> DONE (busy=0, done=1) else loc+1, clear timeout flag, -> G_RUN.
- Backpressure: res_ready low holds EMIT indefinitely; all res_* stable; no core_start issued.
- core_done outside WAIT states ignored. core_done in same cycle as timeout hit: treated as done, no timeout flag.
- start while busy ignored. start in DONE restarts from loc 0.
- Per-location latency without backpressure: 2×(core latency+1)+1 cycles.

Optional Feature:
GOLDEN_REUSE_EN: when defined, golden run executes only for loc 0; subsequent locations go EMIT->F_RUN directly, reusing stored golden ciphertext (NUM_LOCS+1 core_start pulses per campaign). When undefined, golden run repeated every location (2×NUM_LOCS pulses).

Decomposition:
- Package fault_campaign_pkg: state enum type, default DATA_W/LOC_W/HW_W constants, result record struct (loc, golden, diff, hw, timeout).
- Sub-module hamming_weight (DATA_W in, HW_W out, combinational popcount) instantiated once for res_hw.

Test Plan:
- Stub core latency 22, out=K^(fault?1<<loc:0), K=128'h3925841d02dc09fbdc118597196a0b32; start, res_ready=1 -> 128 records, loc 0..127 in order, res_golden=K, res_diff=1<<loc, res_hw=1, res_timeout=0; done=1, busy=0 after last.
- res_ready low 5 cycles at loc 3 -> res_valid held, fields unchanged, zero core_start pulses during stall; loc 4 proceeds after handshake.
- Stub omits core_done on faulted run of loc 10 -> record loc 10 res_timeout=1 after 64 wait cycles; loc 11 res_timeout=0.
- RST_N low during loc 40 F_WAIT -> all outputs 0 asynchronously; after release start -> first record loc 0.
- start pulses while busy ignored; start in DONE -> new campaign, done drops next cycle.
- Count core_start pulses: 129 with GOLDEN_REUSE_EN, 256 without; results identical to first scenario.

Source files
------------

// File: rtl/fault_campaign_ctrl_pkg.sv
// Shared types and default sizes for the fault-campaign controller:
// FSM state encoding and the per-location result record.
package fault_campaign_pkg;

    localparam int DEF_DATA_W   = 128;
    localparam int DEF_LOC_W    = 7;
    localparam int DEF_HW_W     = 8;
    localparam int DEF_NUM_LOCS = 128;
    localparam int DEF_TIMEOUT  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_G_RUN,
        ST_G_WAIT,
        ST_F_RUN,
        ST_F_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_LOC_W-1:0]  loc;
        logic [DEF_DATA_W-1:0] golden;
        logic [DEF_DATA_W-1:0] diff;
        logic [DEF_HW_W-1:0]   hw;
        logic                  timeout;
    } res_rec_t;

endpackage

// File: rtl/fault_campaign_ctrl_hamming_weight.sv
// Combinational population count of a DATA_W-bit vector.
module hamming_weight #(
    parameter int DATA_W = 128,
    parameter int HW_W   = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [HW_W-1:0]   o_hw
);

    always_comb begin
        // NOTE: always_comb uses blocking '=' and starts from a default so no latch is inferred.
        o_hw = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_hw = o_hw + HW_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Walks a single-bit fault through every location of the cipher core and streams one
// golden/diff/Hamming-weight record per location. Optional macro: GOLDEN_REUSE_EN.
module fault_campaign_ctrl
    import fault_campaign_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOC_W    = DEF_LOC_W,
    parameter int NUM_LOCS = DEF_NUM_LOCS,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int HW_W     = DEF_HW_W
) (
    input  logic              CLK_50,
    input  logic              RST_N,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              core_start,
    output logic              core_fault,
    output logic [LOC_W-1:0]  core_fault_loc,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LOC_W-1:0]  res_loc,
    output logic [DATA_W-1:0] res_golden,
    output logic [DATA_W-1:0] res_diff,
    output logic [HW_W-1:0]   res_hw,
    output logic              res_timeout
);

    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [LOC_W-1:0] LAST_LOC = LOC_W'(NUM_LOCS - 1);

    state_t              r_state;
    logic [LOC_W-1:0]    r_loc;
    logic [TO_W-1:0]     r_wait_cnt;
    logic                r_to_flag;
    logic [DATA_W-1:0]   r_golden;
    logic                r_busy;
    logic                r_done;
    logic                r_core_start;
    logic                r_core_fault;
    logic                r_res_valid;
    logic [LOC_W-1:0]    r_res_loc;
    logic [DATA_W-1:0]   r_res_golden;
    logic [DATA_W-1:0]   r_res_diff;
    logic [HW_W-1:0]     r_res_hw;
    logic                r_res_timeout;

    logic [DATA_W-1:0]   w_diff;
    logic [HW_W-1:0]     w_hw;
    logic                w_timeout_hit;
    logic                w_wait_end;

    // A core_done arriving on the last allowed cycle wins over the timeout.
    assign w_timeout_hit = (r_wait_cnt == TO_W'(TIMEOUT - 1)) && !core_done;
    assign w_wait_end    = core_done || w_timeout_hit;
    assign w_diff        = r_golden ^ core_out;

    hamming_weight #(
        .DATA_W (DATA_W),
        .HW_W   (HW_W)
    ) u_hw (
        .i_data (w_diff),
        .o_hw   (w_hw)
    );

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: capture and result registers are reset as well, so every output reads 0 after reset.
            r_state       <= ST_IDLE;
            r_loc         <= '0;
            r_wait_cnt    <= '0;
            r_to_flag     <= 1'b0;
            r_golden      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_fault  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_loc     <= '0;
            r_res_golden  <= '0;
            r_res_diff    <= '0;
            r_res_hw      <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking '<=' so every update sees pre-edge values.
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_G_RUN;
                        r_loc        <= '0;
                        r_to_flag    <= 1'b0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_core_start <= 1'b1;
                    end
                end
                ST_G_RUN: begin
                    r_core_start <= 1'b0;
                    r_wait_cnt   <= '0;
                    r_state      <= ST_G_WAIT;
                end
                ST_G_WAIT: begin
                    if (w_wait_end) begin
                        r_golden     <= core_out;
                        r_to_flag    <= r_to_flag | w_timeout_hit;
                        r_core_start <= 1'b1;
                        r_core_fault <= 1'b1;
                        r_state      <= ST_F_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_F_RUN: begin
                    r_core_start <= 1'b0;
                    r_wait_cnt   <= '0;
                    r_state      <= ST_F_WAIT;
                end
                ST_F_WAIT: begin
                    if (w_wait_end) begin
                        r_core_fault  <= 1'b0;
                        r_res_loc     <= r_loc;
                        r_res_golden  <= r_golden;
                        r_res_diff    <= w_diff;
                        r_res_hw      <= w_hw;
                        r_res_timeout <= r_to_flag | w_timeout_hit;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_EMIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_loc == LAST_LOC) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_loc        <= r_loc + 1'b1;
                            r_to_flag    <= 1'b0;
                            r_core_start <= 1'b1;
`ifdef GOLDEN_REUSE_EN
                            r_core_fault <= 1'b1;
                            r_state      <= ST_F_RUN;
`else
                            r_state      <= ST_G_RUN;
`endif
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign core_start     = r_core_start;
    assign core_fault     = r_core_fault;
    assign core_fault_loc = r_loc;
    assign res_valid      = r_res_valid;
    assign res_loc        = r_res_loc;
    assign res_golden     = r_res_golden;
    assign res_diff       = r_res_diff;
    assign res_hw         = r_res_hw;
    assign res_timeout    = r_res_timeout;

endmodule
